// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM ownership arbiter between initializer, frame reader and processor
// Frame reader has priority; a processor transaction in flight always completes before handover.
module sdram_arbiter #(
    parameter int          READ_BURST_LENGTH = 8,
    parameter logic [1:0]  CMD_NOP           = 2'd0,
    parameter logic [1:0]  CMD_READ          = 2'd1,
    parameter logic [1:0]  CMD_WRITE         = 2'd2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Init_Done,
    input  logic [1:0]  i_Init_Command,
    input  logic [21:0] i_Init_Address,
    input  logic [31:0] i_Init_Write,
    input  logic        i_FR_Request,
    input  logic [1:0]  i_FR_Command,
    input  logic [21:0] i_FR_Address,
    input  logic        i_PR_Request,
    input  logic [1:0]  i_PR_Command,
    input  logic [21:0] i_PR_Address,
    input  logic [31:0] i_PR_Write,
    input  logic        i_Data_Read_Valid,
    input  logic        i_Data_Write_Done,
    output logic        o_FR_Grant,
    output logic        o_PR_Grant,
    output logic [1:0]  o_Owner,
    output logic [1:0]  o_Command,
    output logic [21:0] o_Data_Address,
    output logic [31:0] o_Data_Write
);
    localparam int CNT_W = $clog2(READ_BURST_LENGTH + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FR_OWN,
        ST_PR_OWN,
        ST_TURN
    } state_t;

    state_t             state_q, state_d;
    logic               fr_grant_q, fr_grant_d;
    logic               pr_grant_q, pr_grant_d;
    logic               busy_q, busy_d;
    logic               rd_q, rd_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   beat_next;

    assign beat_next = beat_cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        rd_d           = rd_q;
        beat_cnt_d     = beat_cnt_q;
        o_Owner        = 2'd3;
        o_Command      = CMD_NOP;
        o_Data_Address = '0;
        o_Data_Write   = '0;

        // Completion tracking; beats/done with nothing in flight fall through untouched.
        if (busy_q) begin
            if (rd_q && i_Data_Read_Valid) begin
                if (beat_next == CNT_W'(READ_BURST_LENGTH)) begin
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_next;
                end
            end else if (!rd_q && i_Data_Write_Done) begin
                busy_d = 1'b0;
            end
        end

        case (state_q)
            ST_INIT: begin
                o_Owner        = 2'd0;
                o_Command      = i_Init_Command;
                o_Data_Address = i_Init_Address;
                o_Data_Write   = i_Init_Write;
                if (i_Init_Done) state_d = ST_IDLE;
            end
            ST_IDLE, ST_TURN: begin
                if (i_FR_Request)      state_d = ST_FR_OWN;
                else if (i_PR_Request) state_d = ST_PR_OWN;
                else                   state_d = ST_IDLE;
            end
            ST_FR_OWN: begin
                o_Owner        = 2'd1;
                o_Command      = i_FR_Command;
                o_Data_Address = i_FR_Address;
                if (!busy_q) begin
                    if (!i_FR_Request) begin
                        state_d = ST_TURN;
                    end else if (i_FR_Command == CMD_READ || i_FR_Command == CMD_WRITE) begin
                        busy_d     = 1'b1;
                        rd_d       = (i_FR_Command == CMD_READ);
                        beat_cnt_d = '0;
                    end
                end
            end
            ST_PR_OWN: begin
                o_Owner        = 2'd2;
                o_Data_Address = i_PR_Address;
                o_Data_Write   = i_PR_Write;
                // Frame reader waiting: hold PR off as soon as the bus is quiet.
                if (!busy_q && i_FR_Request) begin
                    o_Command = CMD_NOP;
                    state_d   = ST_TURN;
                end else begin
                    o_Command = i_PR_Command;
                    if (!busy_q) begin
                        if (!i_PR_Request) begin
                            state_d = ST_TURN;
                        end else if (i_PR_Command == CMD_READ || i_PR_Command == CMD_WRITE) begin
                            busy_d     = 1'b1;
                            rd_d       = (i_PR_Command == CMD_READ);
                            beat_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        fr_grant_d = (state_d == ST_FR_OWN);
        pr_grant_d = (state_d == ST_PR_OWN);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_INIT;
            fr_grant_q <= 1'b0;
            pr_grant_q <= 1'b0;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fr_grant_q <= fr_grant_d;
            pr_grant_q <= pr_grant_d;
            busy_q     <= busy_d;
            rd_q       <= rd_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_FR_Grant = fr_grant_q;
    assign o_PR_Grant = pr_grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter
module tb_sdram_arbiter;
    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] RD  = 2'd1;
    localparam logic [1:0] WR  = 2'd2;
    localparam int S_FRG = 0, S_PRG = 1, S_OWN = 2, S_CMD = 3, S_ADDR = 4, S_WR = 5, S_CNT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [1:0]  init_cmd;
    logic [21:0] init_addr;
    logic [31:0] init_wr;
    logic        fr_req;
    logic [1:0]  fr_cmd;
    logic [21:0] fr_addr;
    logic        pr_req;
    logic [1:0]  pr_cmd;
    logic [21:0] pr_addr;
    logic [31:0] pr_wr;
    logic        rd_valid;
    logic        wr_done;
    logic        fr_grant;
    logic        pr_grant;
    logic [1:0]  owner;
    logic [1:0]  cmd;
    logic [21:0] daddr;
    logic [31:0] dwr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    sdram_arbiter dut (
        .i_Clk            (clk),
        .i_Rst_n          (rst_n),
        .i_Init_Done      (init_done),
        .i_Init_Command   (init_cmd),
        .i_Init_Address   (init_addr),
        .i_Init_Write     (init_wr),
        .i_FR_Request     (fr_req),
        .i_FR_Command     (fr_cmd),
        .i_FR_Address     (fr_addr),
        .i_PR_Request     (pr_req),
        .i_PR_Command     (pr_cmd),
        .i_PR_Address     (pr_addr),
        .i_PR_Write       (pr_wr),
        .i_Data_Read_Valid(rd_valid),
        .i_Data_Write_Done(wr_done),
        .o_FR_Grant       (fr_grant),
        .o_PR_Grant       (pr_grant),
        .o_Owner          (owner),
        .o_Command        (cmd),
        .o_Data_Address   (daddr),
        .o_Data_Write     (dwr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_FRG:   return 32'(fr_grant);
            S_PRG:   return 32'(pr_grant);
            S_OWN:   return 32'(owner);
            S_CMD:   return 32'(cmd);
            S_ADDR:  return 32'(daddr);
            S_WR:    return dwr;
            default: return 32'(dut.beat_cnt_q);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    // Advance one active edge, then compare at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic now();
        #1;
        drain();
    endtask

    initial begin
        rst_n = 1'b0; init_done = 1'b0;
        init_cmd = 2'd2; init_addr = 22'h12345; init_wr = 32'hDEADBEEF;
        fr_req = 1'b0; fr_cmd = NOP; fr_addr = 22'h15555;
        pr_req = 1'b1; pr_cmd = NOP; pr_addr = 22'h2AAAA; pr_wr = 32'hCAFEF00D;
        rd_valid = 1'b0; wr_done = 1'b0;

        #12;
        push("rst_frg", S_FRG, 0);  push("rst_prg", S_PRG, 0);
        push("rst_own", S_OWN, 0);  push("rst_cmd", S_CMD, 2);
        push("rst_addr", S_ADDR, 32'h12345); push("rst_wr", S_WR, 32'hDEADBEEF);
        push("rst_cnt", S_CNT, 0);
        drain();

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("init_own", S_OWN, 0); push("init_prg", S_PRG, 0);
            tick();
        end
        init_done = 1'b1;
        push("idle_own", S_OWN, 3); push("idle_cmd", S_CMD, NOP); push("idle_prg", S_PRG, 0);
        tick();
        push("pr_grant", S_PRG, 1); push("pr_own", S_OWN, 2);
        tick();
        init_done = 1'b0;
        push("initdrop_prg", S_PRG, 1); push("initdrop_own", S_OWN, 2);
        tick();

        // Processor write, request dropped while in flight
        pr_cmd = WR;
        push("prw_cmd", S_CMD, WR); push("prw_addr", S_ADDR, 32'h2AAAA); push("prw_wr", S_WR, 32'hCAFEF00D);
        now();
        tick();
        pr_cmd = NOP;
        tick();
        pr_req = 1'b0;
        push("prw_hold_prg", S_PRG, 1); push("prw_hold_addr", S_ADDR, 32'h2AAAA);
        tick();
        push("prw_hold2_prg", S_PRG, 1);
        tick();
        wr_done = 1'b1;
        push("prw_done_prg", S_PRG, 1); push("prw_done_cmd", S_CMD, NOP);
        tick();
        wr_done = 1'b0;
        push("prw_turn_own", S_OWN, 3); push("prw_turn_prg", S_PRG, 0); push("prw_turn_cmd", S_CMD, NOP);
        tick();
        push("prw_idle_own", S_OWN, 3); push("prw_idle_cmd", S_CMD, NOP);
        tick();

        // Stray read beats while idle
        rd_valid = 1'b1;
        push("stray_own", S_OWN, 3); push("stray_cnt", S_CNT, 0);
        tick();
        push("stray2_own", S_OWN, 3); push("stray2_cnt", S_CNT, 0);
        tick();
        rd_valid = 1'b0;

        // Simultaneous requests: frame reader wins and is not preempted
        fr_req = 1'b1; pr_req = 1'b1;
        push("both_frg", S_FRG, 1); push("both_prg", S_PRG, 0); push("both_own", S_OWN, 1);
        tick();
        fr_cmd = RD;
        push("fr_addr", S_ADDR, 32'h15555); push("fr_wr", S_WR, 0); push("fr_cmd", S_CMD, RD);
        now();
        tick();
        fr_cmd = NOP;
        rd_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push($sformatf("fr_beat%0d_frg", i), S_FRG, 1);
            push($sformatf("fr_beat%0d_prg", i), S_PRG, 0);
            tick();
        end
        rd_valid = 1'b0;
        fr_req = 1'b0;
        push("fr_turn_own", S_OWN, 3); push("fr_turn_frg", S_FRG, 0); push("fr_turn_cmd", S_CMD, NOP);
        tick();
        push("pr_after_fr_prg", S_PRG, 1); push("pr_after_fr_own", S_OWN, 2);
        tick();

        // Processor read; frame reader asks after beat 3
        pr_cmd = RD;
        tick();
        pr_cmd = NOP;
        rd_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) fr_req = 1'b1;
            push($sformatf("pre_beat%0d_prg", i), S_PRG, 1);
            push($sformatf("pre_beat%0d_frg", i), S_FRG, 0);
            tick();
        end
        rd_valid = 1'b0;
        pr_cmd = WR;
        push("pre_mask_cmd", S_CMD, NOP); push("pre_mask_prg", S_PRG, 1);
        now();
        push("pre_turn_own", S_OWN, 3); push("pre_turn_prg", S_PRG, 0);
        push("pre_turn_frg", S_FRG, 0); push("pre_turn_cmd", S_CMD, NOP);
        tick();
        pr_cmd = NOP; pr_req = 1'b0;
        push("pre_fr_frg", S_FRG, 1); push("pre_fr_own", S_OWN, 1);
        tick();

        // Reset during frame reader read beat 5
        fr_cmd = RD;
        tick();
        fr_cmd = NOP;
        rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        push("mid_rst_frg", S_FRG, 0); push("mid_rst_prg", S_PRG, 0);
        push("mid_rst_own", S_OWN, 0); push("mid_rst_cmd", S_CMD, 2);
        push("mid_rst_cnt", S_CNT, 0);
        now();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        push("rel_own", S_OWN, 0);
        tick();
        init_done = 1'b1;
        push("rel_idle_own", S_OWN, 3); push("rel_idle_cnt", S_CNT, 0);
        tick();
        push("rel_fr_frg", S_FRG, 1); push("rel_fr_cnt", S_CNT, 0);
        tick();
        rd_valid = 1'b0;

        // Fresh read must need exactly eight beats
        fr_cmd = RD;
        tick();
        fr_cmd = NOP;
        fr_req = 1'b0;
        rd_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push($sformatf("cnt_beat%0d_frg", i), S_FRG, 1);
            tick();
        end
        rd_valid = 1'b0;
        push("cnt_turn_own", S_OWN, 3); push("cnt_turn_frg", S_FRG, 0);
        tick();
        push("cnt_idle_own", S_OWN, 3); push("cnt_idle_cnt", S_CNT, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter READ_BURST_LENGTH, default 8: data_read_valid beats that complete one READ.
REQ-002 SHALL have parameter CMD_NOP/CMD_READ/CMD_WRITE, default 2'd0/2'd1/2'd2: command encodings.
REQ-003 SHALL have ports, one per line:
- i_Clk  in  1  memory clock (MEM_CLK domain); only clock.
- i_Rst_n  in  1  reset; asynchronous, active-low.
- i_Init_Done  in  1  memory initializer finished; sticky once high.
- i_Init_Command  in  2  initializer command.
- i_Init_Address  in  22  initializer address.
- i_Init_Write  in  32  initializer write data.
- i_FR_Request  in  1  frame reader wants SDRAM.
- i_FR_Command  in  2  frame reader command.
- i_FR_Address  in  22  frame reader address.
- i_PR_Request  in  1  processor wants SDRAM.
- i_PR_Command  in  2  processor command.
- i_PR_Address  in  22  processor address.
- i_PR_Write  in  32  processor write data.
- i_Data_Read_Valid  in  1  controller read beat.
- i_Data_Write_Done  in  1  controller write completion.
- o_FR_Grant  out  1  frame reader owns SDRAM.
- o_PR_Grant  out  1  processor owns SDRAM.
- o_Owner  out  2  0 init, 1 frame reader, 2 processor, 3 none.
- o_Command  out  2  to controller.
- o_Data_Address  out  22  to controller.
- o_Data_Write  out  32  to controller.

Function
REQ-004 SHALL implement states INIT, IDLE, FR_OWN, PR_OWN, TURN.
REQ-005 INIT: outputs pass initializer signals; o_Owner=0; on i_Init_Done=1 go IDLE next cycle.
REQ-006 IDLE: o_Command=CMD_NOP, o_Owner=3; i_FR_Request -> FR_OWN; else i_PR_Request -> PR_OWN; both high -> FR_OWN.
REQ-007 o_FR_Grant/o_PR_Grant SHALL be registered, high exactly in FR_OWN/PR_OWN; grant follows request in IDLE by 1 cycle.
REQ-008 In FR_OWN/PR_OWN, o_Command/o_Data_Address pass owner signals combinationally; o_Data_Write = i_PR_Write in PR_OWN, 0 in FR_OWN.
REQ-009 Transaction in flight: set when owner presents READ or WRITE with none in flight; READ clears after READ_BURST_LENGTH i_Data_Read_Valid beats, WRITE clears on i_Data_Write_Done.
REQ-010 Beat counter SHALL be wide enough for READ_BURST_LENGTH, reset to 0 at each new READ.
REQ-011 Owner release: owner drops request with nothing in flight -> TURN.
REQ-012 Preemption: in PR_OWN with i_FR_Request high, PR command SHALL be masked to CMD_NOP from the first cycle nothing is in flight; then TURN; i_PR_Request ignored.
REQ-013 FR_OWN is never preempted; PR waits until FR releases.
REQ-014 Owner dropping request while in flight: hold state, keep passing owner address/data, until completion, then TURN.
REQ-015 TURN: one cycle, o_Command=CMD_NOP, grants low, o_Owner=3; then arbitrate as IDLE (FR priority), or IDLE if no request.
REQ-016 i_Data_Read_Valid/i_Data_Write_Done with nothing in flight SHALL be ignored.
REQ-017 i_Init_Done falling after INIT SHALL be ignored.

Reset
REQ-018 i_Rst_n low SHALL immediately force INIT, grants 0, counter 0, nothing in flight, o_Owner=0, outputs passing initializer signals.
REQ-019 Reset mid-transaction SHALL discard in-flight tracking; after release, stale read beats are ignored per REQ-016.

Verification
REQ-020 Reset, i_Init_Done high cycle 5, i_PR_Request high -> IDLE cycle 6, o_PR_Grant=1 cycle 7, o_Owner=2.
REQ-021 FR and PR request same cycle in IDLE -> o_FR_Grant=1 next cycle, o_PR_Grant stays 0.
REQ-022 PR READ in flight, FR requests after beat 3 -> PR keeps grant through beat 8, one TURN NOP cycle, o_FR_Grant=1 next.
REQ-023 PR WRITE, i_Data_Write_Done after 4 cycles, PR drops request -> TURN then IDLE, o_Command=NOP throughout.
REQ-024 Stray i_Data_Read_Valid in IDLE -> no state change, counter stays 0.
REQ-025 i_Rst_n low during FR READ beat 5 -> grants 0 immediately, o_Owner=0; after release plus i_Init_Done high, normal arbitration resumes.
